// File: rtl/load_store_unit_if.sv
// Bundles the request/response channel and the split data-read and data-write
// memory buses of the load/store unit. The master view belongs to the unit;
// the slave view belongs to the core control path plus the memory fabric.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned RESP_WIDTH = 2
);
  localparam int unsigned STRB = BUS_WIDTH / 8;

  // request / response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // data-read bus
  logic                  dr_addr_valid;
  logic                  dr_addr_ready;
  logic [BUS_WIDTH-1:0]  dr_addr;
  logic                  dr_data_valid;
  logic                  dr_data_ready;
  logic [BUS_WIDTH-1:0]  dr_data;

  // data-write bus
  logic                  dw_data_addr_valid;
  logic                  dw_data_addr_ready;
  logic [BUS_WIDTH-1:0]  dw_addr;
  logic [BUS_WIDTH-1:0]  dw_data;
  logic [STRB-1:0]       dw_strobe;
  logic                  dw_resp_valid;
  logic                  dw_resp_ready;
  logic [RESP_WIDTH-1:0] dw_resp;

  modport master (
    input  req_valid, req_store, req_funct, req_addr, req_wdata, rsp_ready,
    input  dr_addr_ready, dr_data_valid, dr_data,
    input  dw_data_addr_ready, dw_resp_valid, dw_resp,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output dr_addr_valid, dr_addr, dr_data_ready,
    output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready
  );

  modport slave (
    output req_valid, req_store, req_funct, req_addr, req_wdata, rsp_ready,
    output dr_addr_ready, dr_data_valid, dr_data,
    output dw_data_addr_ready, dw_resp_valid, dw_resp,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  dr_addr_valid, dr_addr, dr_data_ready,
    input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the copperv core: one outstanding load or store, byte-lane
// steering onto a 32- or 64-bit bus, sign/zero extension of loads, and error
// reporting for misaligned accesses, illegal funct3 and failed writes.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned RESP_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.master bus
);
  localparam int unsigned STRB = BUS_WIDTH / 8;
  localparam int unsigned OFS  = $clog2(STRB);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  rdy_q;
  logic [2:0]            funct_q;
  logic [OFS-1:0]        ofs_q;
  logic [BUS_WIDTH-1:0]  dr_addr_q, dw_addr_q, dw_data_q;
  logic [STRB-1:0]       dw_strobe_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  req_bad;
  logic [OFS-1:0]        req_ofs;
  logic [BUS_WIDTH-1:0]  req_aligned;
  logic [BUS_WIDTH-1:0]  wd_ext;
  logic [STRB-1:0]       strb_base;
  logic [DATA_WIDTH-1:0] ld_word, ld_ext;

  assign req_ofs     = bus.req_addr[OFS-1:0];
  assign req_aligned = BUS_WIDTH'({bus.req_addr[31:OFS], {OFS{1'b0}}});

  // Classify the incoming request: illegal funct3 or misaligned for its size.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_funct)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = bus.req_addr[0];
      3'b010:         req_bad = |bus.req_addr[1:0];
      default:        req_bad = 1'b1;
    endcase
    if (bus.req_store && bus.req_funct[2]) req_bad = 1'b1;
  end

  // Size-dependent store data and strobe before shifting into their lanes.
  always_comb begin
    wd_ext    = '0;
    strb_base = '0;
    case (bus.req_funct[1:0])
      2'b00: begin
        wd_ext    = BUS_WIDTH'(bus.req_wdata[7:0]);
        strb_base = STRB'(4'b0001);
      end
      2'b01: begin
        wd_ext    = BUS_WIDTH'(bus.req_wdata[15:0]);
        strb_base = STRB'(4'b0011);
      end
      default: begin
        wd_ext    = BUS_WIDTH'(bus.req_wdata);
        strb_base = STRB'(4'b1111);
      end
    endcase
  end

  // Extract the addressed lanes of the read bus and extend per funct3.
  always_comb begin
    ld_word = DATA_WIDTH'(bus.dr_data >> {ofs_q, 3'b000});
    case (funct_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_word[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; bad requests skip the bus and answer straight away.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid && rdy_q) begin
        accept = 1'b1;
        if (req_bad)            state_d = RESP;
        else if (bus.req_store) state_d = WR_REQ;
        else                    state_d = RD_ADDR;
      end
      RD_ADDR: if (bus.dr_addr_ready)      state_d = RD_DATA;
      RD_DATA: if (bus.dr_data_valid)      state_d = RESP;
      WR_REQ:  if (bus.dw_data_addr_ready) state_d = WR_RESP;
      WR_RESP: if (bus.dw_resp_valid)      state_d = RESP;
      RESP:    if (bus.rsp_ready)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields, bus payloads and the response, all registered.
  // rdy_q keeps req_ready low while reset is held even though state is IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      funct_q     <= '0;
      ofs_q       <= '0;
      dr_addr_q   <= '0;
      dw_addr_q   <= '0;
      dw_data_q   <= '0;
      dw_strobe_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        funct_q    <= bus.req_funct;
        ofs_q      <= req_ofs;
        rsp_data_q <= '0;
        rsp_err_q  <= req_bad;
        if (!req_bad && !bus.req_store) dr_addr_q <= req_aligned;
        if (!req_bad && bus.req_store) begin
          dw_addr_q   <= req_aligned;
          dw_data_q   <= wd_ext << {req_ofs, 3'b000};
          dw_strobe_q <= strb_base << req_ofs;
        end
      end
      if (state_q == RD_DATA && bus.dr_data_valid) rsp_data_q <= ld_ext;
      if (state_q == WR_RESP && bus.dw_resp_valid)
        rsp_err_q <= (bus.dw_resp != RESP_WIDTH'(0));
    end
  end

  assign bus.req_ready          = rdy_q && (state_q == IDLE);
  assign bus.dr_addr_valid      = (state_q == RD_ADDR);
  assign bus.dr_data_ready      = (state_q == RD_DATA);
  assign bus.dw_data_addr_valid = (state_q == WR_REQ);
  assign bus.dw_resp_ready      = (state_q == WR_RESP);
  assign bus.rsp_valid          = (state_q == RESP);
  assign bus.dr_addr            = dr_addr_q;
  assign bus.dw_addr            = dw_addr_q;
  assign bus.dw_data            = dw_data_q;
  assign bus.dw_strobe          = dw_strobe_q;
  assign bus.rsp_data           = rsp_data_q;
  assign bus.rsp_err            = rsp_err_q;
endmodule
